// File: rtl/fifo_drain_stream_buf2.sv
// stream_buf2: 2-entry register FIFO (head always oldest). wr at the tail, rd at the head.
// Latency: a write is visible on dout the cycle after it is accepted.
// Backpressure: none internally; the caller must never write into a full buffer.
module stream_buf2 #(
    parameter int DATA_ = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [DATA_-1:0] din,
    input  logic             rd,
    output logic [DATA_-1:0] dout,
    output logic [1:0]       occ
);
    localparam logic [1:0] DEPTH = 2'd2;

    logic [DATA_-1:0] head_q;
    logic [DATA_-1:0] tail_q;
    logic [1:0]       occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + {1'b0, wr} - {1'b0, rd};
        end
    end

    // Shift organisation: a read moves tail to head; a write lands in the first free slot.
    always_ff @(posedge clk) begin
        if (rd) begin
            head_q <= (wr && occ_q == 2'd1) ? din : tail_q;
            if (wr && occ_q == DEPTH) begin
                tail_q <= din;
            end
        end else if (wr) begin
            if (occ_q == 2'd0) begin
                head_q <= din;
            end else begin
                tail_q <= din;
            end
        end
    end

    assign dout = head_q;
    assign occ  = occ_q;

    a_occ_max: assert property (@(posedge clk) disable iff (rst) occ_q <= DEPTH);
    a_no_overrun: assert property (@(posedge clk) disable iff (rst) (wr && !rd) |-> (occ_q < DEPTH));
endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: pops a BRAM FIFO (1-cycle read latency) into a valid/ready stream; optional counter under FIFO_DRAIN_CNT_EN.
// Latency: fifo_re in cycle N -> m_valid in cycle N+2; 1 word/cycle under continuous m_ready.
// Backpressure: pops are issued only while buffered + in-flight words stay below 2; m_data holds while m_valid && !m_ready.
module fifo_drain #(
    parameter int DATA_ = 8,
    parameter int ADDR_ = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             fifo_re,
    input  logic [ADDR_:0]   fifo_fill,
    input  logic [DATA_-1:0] fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DATA_-1:0] m_data,
    output logic             busy
`ifdef FIFO_DRAIN_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [31:0]      cnt
`endif
);
    logic       inflight;
    logic       pop;
    logic [1:0] occ;
    logic [2:0] committed;

    assign pop       = m_valid & m_ready;
    assign committed = {1'b0, occ} + {2'b00, inflight};

    // A pop in this cycle frees a slot, hence the m_ready -> fifo_re path for full throughput.
    assign fifo_re = !rst && en && (fifo_fill != '0) && (committed < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_re;
        end
    end

    stream_buf2 #(
        .DATA_(DATA_)
    ) u_buf (
        .clk (clk),
        .rst (rst),
        .wr  (inflight),
        .din (fifo_dout),
        .rd  (pop),
        .dout(m_data),
        .occ (occ)
    );

    assign m_valid = (occ != 2'd0);
    assign busy    = m_valid | inflight;

`ifdef FIFO_DRAIN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: behavioural BRAM FIFO on the read side, scoreboard on the stream side.
module tb_fifo_drain;
    localparam int DATA_ = 8;
    localparam int ADDR_ = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             m_ready = 1'b0;
    logic             fifo_re;
    logic             m_valid;
    logic             busy;
    logic [ADDR_:0]   fifo_fill = '0;
    logic [DATA_-1:0] fifo_dout = '0;
    logic [DATA_-1:0] m_data;
`ifdef FIFO_DRAIN_CNT_EN
    logic             cnt_clr = 1'b0;
    logic [31:0]      cnt;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int re_cnt = 0;

    logic [7:0] mem_q[$];
    logic [7:0] exp_q[$];
    logic       push_en = 1'b0;
    logic [7:0] push_dat = '0;

    fifo_drain #(
        .DATA_(DATA_),
        .ADDR_(ADDR_)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .fifo_re  (fifo_re),
        .fifo_fill(fifo_fill),
        .fifo_dout(fifo_dout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .busy     (busy)
`ifdef FIFO_DRAIN_CNT_EN
        ,
        .cnt_clr  (cnt_clr),
        .cnt      (cnt)
`endif
    );

    always #5 clk = ~clk;

    // BRAM FIFO model: registered fill, read data one cycle after the pop.
    always @(posedge clk) begin
        if (fifo_re) begin
            re_cnt++;
            n_checks++;
            if (mem_q.size() == 0) begin
                n_fail++;
                $display("FAIL re_on_empty actual=pop_with_fill_0 required=no_pop");
            end else begin
                fifo_dout <= mem_q.pop_front();
            end
        end
        if (push_en) mem_q.push_back(push_dat);
        fifo_fill <= 9'(mem_q.size());
    end

    // Scoreboard monitor: every accepted word must be the oldest expected one.
    always @(negedge clk) begin
        logic [7:0] e;
        if (m_valid && m_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected actual=%02h required=no_word", m_data);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    n_fail++;
                    $display("FAIL sb_data actual=%02h required=%02h", m_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            mem_q.push_back(base + 8'(i));
            exp_q.push_back(base + 8'(i));
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        push_en = 1'b1;
        push_dat = d;
        exp_q.push_back(d);
        tick();
        push_en = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int k = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0 || busy) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, (exp_q.size() == 0 && mem_q.size() == 0 && !busy)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int re_first;
        int v_first;
        int v_last;
        int v_n;
        int k;

        // Reset with a non-empty FIFO
        preload(10, 8'h01);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_fifo_re", {31'd0, fifo_re}, 32'd0);
            check("rst_m_valid", {31'd0, m_valid}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end

        // Streaming at full rate
        tick();
        rst = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;
        re_cnt = 0;
        re_first = -1;
        v_first = -1;
        v_last = -1;
        v_n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fifo_re && re_first < 0) re_first = i;
            if (m_valid) begin
                if (v_first < 0) v_first = i;
                v_last = i;
                v_n++;
            end
        end
        check("stream_latency", v_first - re_first, 32'd2);
        check("stream_run_len", v_last - v_first + 1, 32'd10);
        check("stream_valid_cycles", v_n, 32'd10);
        check("stream_re_pulses", re_cnt, 32'd10);
        check("stream_all_seen", exp_q.size(), 32'd0);

        // Backpressure: only two pops, head word held
        tick();
        m_ready = 1'b0;
        re_cnt = 0;
        preload(4, 8'h01);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 4) begin
                check("bp_m_valid", {31'd0, m_valid}, 32'd1);
                check("bp_m_data_hold", {24'd0, m_data}, 32'h01);
            end
        end
        check("bp_re_pulses", re_cnt, 32'd2);
        check("bp_busy", {31'd0, busy}, 32'd1);
        tick();
        m_ready = 1'b1;
        wait_drain("bp_drain", 40);

        // Pause: en low for 3 cycles mid-stream
        tick();
        preload(8, 8'h21);
        tick();
        tick();
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pause_no_re", {31'd0, fifo_re}, 32'd0);
        end
        tick();
        en = 1'b1;
        wait_drain("pause_drain", 40);

        // Empty boundary: fill goes 1 -> 0, later word still delivered
        tick();
        push_word(8'h5A);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("empty_no_re", {31'd0, fifo_re & (fifo_fill == '0)}, 32'd0);
        end
        tick();
        push_word(8'h77);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("empty2_no_re", {31'd0, fifo_re & (fifo_fill == '0)}, 32'd0);
        end
        wait_drain("empty_drain", 20);

`ifdef FIFO_DRAIN_CNT_EN
        // Counter: total so far, reset clear, 7 words, clear coinciding with a pop
        @(negedge clk);
        check("cnt_total", cnt, 32'd24);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("cnt_after_rst", cnt, 32'd0);
        tick();
        preload(7, 8'h31);
        wait_drain("cnt_drain7", 40);
        @(negedge clk);
        check("cnt_seven", cnt, 32'd7);
        tick();
        m_ready = 1'b0;
        preload(1, 8'h38);
        k = 0;
        while (!m_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("cnt_eighth_valid", {31'd0, m_valid}, 32'd1);
        tick();
        m_ready = 1'b1;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("cnt_clr_with_pop", cnt, 32'd0);
        wait_drain("cnt_drain8", 20);
`endif

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
- Read-side engine for the block-RAM FIFO.
- Pops words from the FIFO read port (re / fill / dout, 1-cycle read latency) and presents them as a valid/ready stream to downstream consumers.
- Hides the BRAM read latency with a 2-entry output buffer. Sustains 1 word/cycle under continuous ready.
- Sits between any BRAM FIFO instance and a stream sink (UART TX, DMA writer, ...).

Parameters:
- DATA_, 8, word width in bits (matches the FIFO).
- ADDR_, 8, FIFO address width; the fill input is ADDR_+1 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  drain enable; 0 stops new FIFO pops, buffered words still drain
- fifo_re  out  1  pop strobe to the FIFO read port
- fifo_fill  in  ADDR_+1  FIFO fill count, registered
- fifo_dout  in  DATA_  FIFO read data; word popped in cycle N is valid in cycle N+1
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts
- m_data  out  DATA_  output word
- busy  out  1  high while occ != 0 or inflight == 1

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high (rst), sampled on posedge clk.
- State:
  - occ: 0..2, buffer occupancy.
  - inflight: 0..1, a pop was issued last cycle and its data arrives this cycle.
  - buf[0..1] with head/tail index (or shift register): head is always the oldest word.
- pop = m_valid && m_ready.
- fifo_re = !rst && en && (fifo_fill != 0) && (occ + inflight - pop) < 2. The combinational path m_ready -> fifo_re is intentional; it is required for full throughput.
- On posedge:
  - inflight <= fifo_re.
  - If inflight == 1, fifo_dout is written at the tail.
  - If pop, the head is removed.
  - occ <= occ + inflight - pop. Simultaneous write and pop is legal. The write at occ==2 cannot happen by construction; the assertion "occ never exceeds 2" must hold.
- m_valid = (occ != 0). m_data = head word, stable while m_valid && !m_ready (AXI-style hold).
- Ordering: strict FIFO order, no loss, no duplication.
- Latency: FIFO non-empty with an empty engine -> fifo_re in cycle N -> m_valid in cycle N+2.
- Throughput: 1 word/cycle with continuous m_ready and fill >= 1.
- FIFO empty (fill == 0): no pop issued. A word written into the FIFO becomes visible via fill on the following cycle.
- en deasserted mid-stream: an in-flight word is still captured; the buffer keeps draining normally.
- m_ready low with buffer full (occ + inflight == 2): fifo_re stays 0. No overrun.
- Reset value of every output: fifo_re=0, m_valid=0, busy=0. m_data is don't-care while m_valid=0.
- Reset mid-operation: occ=0, inflight=0, and any in-flight word is discarded. The FIFO is reset alongside; reset only this block if the data loss is acceptable.

Optional Feature:
- Macro FIFO_DRAIN_CNT_EN.
- Defined:
  - Adds output cnt (32 bits), counting accepted words (pop).
  - Cleared by rst; wraps modulo 2^32.
  - Adds input cnt_clr (1 bit): synchronous clear. If it coincides with a pop, the result is 0.
- Undefined: neither port exists and the counter logic is removed; all other behaviour is identical.

Decomposition:
- No shared package needed. The buffer depth is a localparam (2) inside the block.
- One natural sub-module: stream_buf2, a 2-entry register FIFO with wr / din / rd / dout / occ. It is reusable for other latency-hiding front ends.
- fifo_drain holds the credit logic, the inflight flag and the optional counter.

Test Plan:
- Reset: rst=1 for 2 cycles with fill=5 -> fifo_re=0, m_valid=0, busy=0 throughout.
- Streaming: preload 10 words 0x01..0x0A with m_ready=1, en=1 -> first m_valid 2 cycles after the first fifo_re, then 10 consecutive valid cycles carrying 0x01..0x0A; exactly 10 fifo_re pulses.
- Backpressure: 4 words, m_ready=0 -> exactly 2 fifo_re pulses, occ=2, and m_data=0x01 held stable; then release m_ready -> 0x01..0x04 in order.
- Pause: en=0 for 3 cycles mid-stream -> no fifo_re during the pause; the in-flight word plus buffered words are still delivered; the stream resumes without gaps or duplicates.
- Empty boundary: fill toggles 1 -> 0 while the consumer pops each cycle -> no fifo_re while fill==0; a word written later appears on m_data.
- FIFO_DRAIN_CNT_EN defined, 7 words accepted -> cnt=7; pulse cnt_clr together with the 8th pop -> cnt=0.
